// File: rtl/output_channel_sched.sv
// ---------------------------------------------------------------------------
// output_channel_sched
//
// Output-channel scheduler for a two-virtual-channel link. Four requesters
// compete for a single-flit output slot belonging to the VC selected by
// `polarity`. Each VC has its own slot and its own round-robin pointer. Only
// the current VC's slot and pointer are touched in a given cycle.
//
// Ports
//   clk                 single clock, rising-edge state updates
//   reset               synchronous, active-high; empties both slots and
//                       gives requester 0 first priority on both VCs
//   polarity            current virtual channel (0 = VC0, 1 = VC1)
//   req_0..req_3        requester i has a flit for the current VC
//   data_0..data_3      flit of requester i (valid when req_i = 1)
//   gnt_0..gnt_3        combinational; flit of requester i is taken this edge
//   out_valid           current-VC slot holds a flit
//   out_data            flit held in the current-VC slot
//   out_vc              echoes polarity
//   out_ready           downstream takes out_data this edge when out_valid = 1
// ---------------------------------------------------------------------------
module output_channel_sched #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              req_2,
  input  logic              req_3,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] data_3,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              gnt_2,
  output logic              gnt_3,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vc,
  input  logic              out_ready
);

  // Per-VC state, indexed by polarity.
  logic [1:0]             slot_v_q,    slot_v_d;
  logic [1:0][DATA_W-1:0] slot_data_q, slot_data_d;
  logic [1:0][1:0]        ptr_q,       ptr_d;

  logic [3:0]        req_vec;
  logic [3:0]        gnt_vec;
  logic [DATA_W-1:0] data_sel;
  logic              drain;
  logic              accept_en;
  logic              found;
  logic              grant;
  logic [1:0]        win;
  logic [1:0]        cand;

  assign req_vec = {req_3, req_2, req_1, req_0};

  // Output view of the current VC. Gating with reset hides flits that the
  // reset edge is about to discard, so they can never be drained.
  assign out_valid = slot_v_q[polarity] & ~reset;
  assign out_data  = slot_data_q[polarity];
  assign out_vc    = polarity;

  assign drain = out_valid & out_ready;

  // The slot can take a flit if it is empty or is being emptied this edge.
  assign accept_en = ~reset & (~slot_v_q[polarity] | drain);

  // Round-robin search: ptr+1, ptr+2, ptr+3, then ptr itself (offset 4 wraps
  // to 0 in two bits), so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = ptr_q[polarity] + k[1:0];
      if (!found && req_vec[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign grant = found & accept_en;

  always_comb begin
    gnt_vec = '0;
    if (grant) begin
      gnt_vec[win] = 1'b1;
    end
  end

  assign gnt_0 = gnt_vec[0];
  assign gnt_1 = gnt_vec[1];
  assign gnt_2 = gnt_vec[2];
  assign gnt_3 = gnt_vec[3];

  always_comb begin
    data_sel = data_0;
    unique case (win)
      2'd0: data_sel = data_0;
      2'd1: data_sel = data_1;
      2'd2: data_sel = data_2;
      2'd3: data_sel = data_3;
      default: data_sel = data_0;
    endcase
  end

  // Grant takes precedence over drain: a same-edge drain+grant simply
  // overwrites the slot, keeping valid high with no bubble.
  always_comb begin
    slot_v_d    = slot_v_q;
    slot_data_d = slot_data_q;
    ptr_d       = ptr_q;
    if (grant) begin
      slot_v_d[polarity]    = 1'b1;
      slot_data_d[polarity] = data_sel;
      ptr_d[polarity]       = win;
    end else if (drain) begin
      slot_v_d[polarity] = 1'b0;
    end
  end

  // Pointers reset to 3 on both VCs so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_v_q    <= '0;
      slot_data_q <= '0;
      ptr_q       <= '1;
    end else begin
      slot_v_q    <= slot_v_d;
      slot_data_q <= slot_data_d;
      ptr_q       <= ptr_d;
    end
  end

endmodule
